// File: rtl/ecc_pkg.sv
// Shared ECC definitions used by the scalar-multiply sequencer and the point ALU.
// Holds point layout, ALU opcode encodings and the sequencer state encoding.
package ecc_pkg;

  localparam int unsigned K_W     = 64;
  localparam int unsigned COORD_W = 64;
  localparam int unsigned PT_W    = 2 * COORD_W + 1;
  localparam int unsigned CNT_W   = 6;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_DOUBLE = 2'b01;

  localparam logic [PT_W-1:0] PT_INF = {1'b1, 128'b0};

  // Point layout: [128] infinity flag, [127:64] x, [63:0] y.
  typedef struct packed {
    logic               inf;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DBL_REQ,
    S_DBL_WAIT,
    S_ADD_REQ,
    S_ADD_WAIT,
    S_FIN
  } state_t;

endpackage

// File: rtl/scalar_mul_ctrl.sv
// Left-to-right double-and-add sequencer computing k*P through an external point ALU.
// One ALU operation is outstanding at a time; the accumulator lives here.
module scalar_mul_ctrl
  import ecc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [K_W-1:0]  k,
  input  logic [PT_W-1:0] base_pt,
  output logic            busy,
  output logic            done,
  output logic [PT_W-1:0] result,
  output logic            alu_en,
  output logic [PT_W-1:0] alu_P,
  output logic [PT_W-1:0] alu_Q,
  output logic [1:0]      alu_op,
  input  logic [PT_W-1:0] alu_R,
  input  logic            alu_done
);

  state_t            state;
  state_t            state_d;
  logic [K_W-1:0]    k_r;
  logic [K_W-1:0]    k_d;
  point_t            base_r;
  point_t            base_d;
  point_t            acc;
  point_t            acc_d;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  idx_d;

  logic              busy_d;
  logic              done_d;
  logic [PT_W-1:0]   result_d;
  logic              alu_en_d;
  logic [PT_W-1:0]   alu_p_d;
  logic [PT_W-1:0]   alu_q_d;
  logic [1:0]        alu_op_d;

  logic              cur_bit;
  logic              idx_zero;

  assign cur_bit  = k_r[idx];
  assign idx_zero = (idx == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state and accumulator/index update
  always_comb begin
    state_d = state;
    k_d     = k_r;
    base_d  = base_r;
    acc_d   = acc;
    idx_d   = idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          k_d     = k;
          base_d  = point_t'(base_pt);
          idx_d   = CNT_W'(K_W - 1);
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (base_r.inf) begin
          acc_d   = point_t'(PT_INF);
          state_d = S_FIN;
        end else if (cur_bit) begin
          acc_d = base_r;
          if (idx_zero) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx - CNT_W'(1);
            state_d = S_DBL_REQ;
          end
        end else if (idx_zero) begin
          acc_d   = point_t'(PT_INF);
          state_d = S_FIN;
        end else begin
          idx_d = idx - CNT_W'(1);
        end
      end
      S_DBL_REQ: begin
        state_d = S_DBL_WAIT;
      end
      S_DBL_WAIT: begin
        if (alu_done) begin
          acc_d = point_t'(alu_R);
          if (cur_bit) begin
            state_d = S_ADD_REQ;
          end else if (idx_zero) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx - CNT_W'(1);
            state_d = S_DBL_REQ;
          end
        end
      end
      S_ADD_REQ: begin
        // O + P = P, so an infinite accumulator skips the ALU call
        if (acc.inf) begin
          acc_d = base_r;
          if (idx_zero) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx - CNT_W'(1);
            state_d = S_DBL_REQ;
          end
        end else begin
          state_d = S_ADD_WAIT;
        end
      end
      S_ADD_WAIT: begin
        if (alu_done) begin
          acc_d = point_t'(alu_R);
          if (idx_zero) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx - CNT_W'(1);
            state_d = S_DBL_REQ;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    busy_d   = busy;
    done_d   = 1'b0;
    result_d = result;
    alu_en_d = 1'b0;
    alu_p_d  = alu_P;
    alu_q_d  = alu_Q;
    alu_op_d = alu_op;
    case (state)
      S_IDLE: begin
        if (state_d == S_SCAN) begin
          busy_d = 1'b1;
        end
      end
      S_DBL_REQ: begin
        alu_en_d = 1'b1;
        alu_p_d  = acc;
        alu_q_d  = acc;
        alu_op_d = ALU_OP_DOUBLE;
      end
      S_ADD_REQ: begin
        // Adding a point to itself is undefined for the add formula; double it instead
        if (!acc.inf) begin
          alu_en_d = 1'b1;
          alu_p_d  = acc;
          alu_q_d  = base_r;
          alu_op_d = (acc == base_r) ? ALU_OP_DOUBLE : ALU_OP_ADD;
        end
      end
      default: begin
      end
    endcase
    // done/busy/result are presented during the FIN cycle itself
    if ((state_d == S_FIN) && (state != S_FIN)) begin
      done_d   = 1'b1;
      busy_d   = 1'b0;
      result_d = acc_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r    <= '0;
      base_r <= point_t'(PT_INF);
      acc    <= point_t'(PT_INF);
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= PT_INF;
      alu_en <= 1'b0;
      alu_P  <= PT_INF;
      alu_Q  <= PT_INF;
      alu_op <= ALU_OP_ADD;
    end else begin
      k_r    <= k_d;
      base_r <= base_d;
      acc    <= acc_d;
      idx    <= idx_d;
      busy   <= busy_d;
      done   <= done_d;
      result <= result_d;
      alu_en <= alu_en_d;
      alu_P  <= alu_p_d;
      alu_Q  <= alu_q_d;
      alu_op <= alu_op_d;
    end
  end

endmodule

// File: tb/tb_scalar_mul_ctrl.sv
// Bench for scalar_mul_ctrl: stub point ALU plus a bit-by-bit double-and-add reference model.
module tb_scalar_mul_ctrl;
  import ecc_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [K_W-1:0]  k = '0;
  logic [PT_W-1:0] base_pt = '0;
  logic            busy;
  logic            done;
  logic [PT_W-1:0] result;
  logic            alu_en;
  logic [PT_W-1:0] alu_P;
  logic [PT_W-1:0] alu_Q;
  logic [1:0]      alu_op;
  logic [PT_W-1:0] alu_R = '0;
  logic            alu_done = 1'b0;

  scalar_mul_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k), .base_pt(base_pt),
    .busy(busy), .done(done), .result(result),
    .alu_en(alu_en), .alu_P(alu_P), .alu_Q(alu_Q), .alu_op(alu_op),
    .alu_R(alu_R), .alu_done(alu_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stub ALU behaviour: 0 = operand hash, 1 = DOUBLE returns base, 2 = DOUBLE returns infinity
  int              stub_mode = 0;
  int              stub_lat  = 3;
  logic [PT_W-1:0] cur_base  = '0;
  int              stub_cnt  = 0;
  logic [PT_W-1:0] stub_res  = '0;

  function automatic logic [PT_W-1:0] alu_fn(input logic [1:0] op, input logic [PT_W-1:0] p,
                                             input logic [PT_W-1:0] q, input int mode,
                                             input logic [PT_W-1:0] b);
    logic [63:0] x;
    logic [63:0] y;
    if (op == ALU_OP_DOUBLE && mode == 1) return b;
    if (op == ALU_OP_DOUBLE && mode == 2) return PT_INF;
    x = p[127:64] * 64'd3 + q[63:0] + ((op == ALU_OP_DOUBLE) ? 64'h1111 : 64'h2222);
    y = {p[31:0], p[63:32]} ^ q[127:64] ^ 64'h5A5A_0000_C3C3;
    return {1'b0, x, y};
  endfunction

  always @(posedge clk) begin
    alu_done <= 1'b0;
    if (stub_cnt > 0) begin
      if (stub_cnt == 1) begin
        alu_done <= 1'b1;
        alu_R    <= stub_res;
      end
      stub_cnt <= stub_cnt - 1;
    end
    if (alu_en === 1'b1) begin
      stub_res <= alu_fn(alu_op, alu_P, alu_Q, stub_mode, cur_base);
      stub_cnt <= stub_lat;
    end
  end

  // Monitor: records issued ops, wide pulses, operand changes while in flight, done pulses
  logic [1:0]      q_op[$];
  logic [PT_W-1:0] q_P[$];
  logic [PT_W-1:0] q_Q[$];
  int              wide_cnt = 0;
  int              unstable_cnt = 0;
  int              done_cnt = 0;
  logic            en_prev = 1'b0;
  bit              in_flight = 1'b0;
  logic [1:0]      hold_op;
  logic [PT_W-1:0] hold_P;
  logic [PT_W-1:0] hold_Q;

  always @(posedge clk) begin
    if (alu_en === 1'b1) begin
      q_op.push_back(alu_op);
      q_P.push_back(alu_P);
      q_Q.push_back(alu_Q);
      if (en_prev === 1'b1) wide_cnt++;
      in_flight = 1'b1;
      hold_op = alu_op;
      hold_P  = alu_P;
      hold_Q  = alu_Q;
    end else if (in_flight && rst_n &&
                 (alu_op !== hold_op || alu_P !== hold_P || alu_Q !== hold_Q)) begin
      unstable_cnt++;
    end
    if (alu_done || !rst_n) in_flight = 1'b0;
    if (done === 1'b1) done_cnt++;
    en_prev = alu_en;
  end

  // Reference model results
  logic [1:0]      m_op[$];
  logic [PT_W-1:0] m_P[$];
  logic [PT_W-1:0] m_Q[$];

  task automatic model(input logic [K_W-1:0] kk, input logic [PT_W-1:0] bb, input int mode,
                       output logic [PT_W-1:0] res);
    logic [PT_W-1:0] acc;
    logic [1:0]      op;
    int              msb;
    m_op.delete();
    m_P.delete();
    m_Q.delete();
    if (bb[128] || kk == '0) begin
      res = PT_INF;
      return;
    end
    msb = K_W - 1;
    while (!kk[msb]) msb--;
    acc = bb;
    for (int i = msb - 1; i >= 0; i--) begin
      m_op.push_back(ALU_OP_DOUBLE); m_P.push_back(acc); m_Q.push_back(acc);
      acc = alu_fn(ALU_OP_DOUBLE, acc, acc, mode, bb);
      if (kk[i]) begin
        if (acc[128]) begin
          acc = bb;
        end else begin
          op = (acc == bb) ? ALU_OP_DOUBLE : ALU_OP_ADD;
          m_op.push_back(op); m_P.push_back(acc); m_Q.push_back(bb);
          acc = alu_fn(op, acc, bb, mode, bb);
        end
      end
    end
    res = acc;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [K_W-1:0] kk, input logic [PT_W-1:0] bb,
                        input int mode, input int lat, input bit inject, input int exp_lat);
    logic [PT_W-1:0] exp_res;
    int base_idx, wide0, unst0, done0, cyc, n_got;
    bit seen;
    model(kk, bb, mode, exp_res);
    stub_mode = mode;
    stub_lat  = lat;
    cur_base  = bb;
    base_idx  = q_op.size();
    wide0     = wide_cnt;
    unst0     = unstable_cnt;
    done0     = done_cnt;
    @(negedge clk);
    start = 1'b1; k = kk; base_pt = bb;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({name, " busy_rise"}, 192'(busy), 192'(1'b1));
    seen = 1'b0;
    while (cyc < 4000) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (inject && cyc == 5) begin
        start = 1'b1; k = ~kk; base_pt = {1'b0, ~bb[127:0]};
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk({name, " done_seen"}, 192'(seen), 192'(1'b1));
    if (exp_lat != 0) chk({name, " latency"}, 192'(cyc), 192'(exp_lat));
    chk({name, " result"}, 192'(result), 192'(exp_res));
    chk({name, " busy_at_done"}, 192'(busy), 192'(1'b0));
    n_got = q_op.size() - base_idx;
    chk({name, " op_count"}, 192'(n_got), 192'(m_op.size()));
    for (int i = 0; i < m_op.size() && i < n_got; i++) begin
      chk($sformatf("%s op%0d kind", name, i), 192'(q_op[base_idx + i]), 192'(m_op[i]));
      chk($sformatf("%s op%0d P", name, i), 192'(q_P[base_idx + i]), 192'(m_P[i]));
      chk($sformatf("%s op%0d Q", name, i), 192'(q_Q[base_idx + i]), 192'(m_Q[i]));
    end
    // A start coinciding with done must not be accepted
    start = 1'b1; k = kk ^ 64'h1; base_pt = bb;
    @(negedge clk);
    start = 1'b0;
    chk({name, " done_single"}, 192'(done), 192'(1'b0));
    chk({name, " start_at_done_ignored"}, 192'(busy), 192'(1'b0));
    chk({name, " done_pulses"}, 192'(done_cnt - done0), 192'(1));
    chk({name, " wide_pulses"}, 192'(wide_cnt - wide0), 192'(0));
    chk({name, " operand_stable"}, 192'(unstable_cnt - unst0), 192'(0));
  endtask

  function automatic logic [PT_W-1:0] rand_pt();
    return {1'b0, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [PT_W-1:0] b;
    logic [K_W-1:0]  kr;
    int w;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 192'(busy), 192'(1'b0));
    chk("reset done", 192'(done), 192'(1'b0));
    chk("reset alu_en", 192'(alu_en), 192'(1'b0));
    chk("reset result", 192'(result), 192'(PT_INF));
    chk("reset alu_P", 192'(alu_P), 192'(PT_INF));
    chk("reset alu_Q", 192'(alu_Q), 192'(PT_INF));
    chk("reset alu_op", 192'(alu_op), 192'(2'b00));
    rst_n = 1'b1;

    run_op("k0", 64'h0, rand_pt(), 0, 3, 1'b0, 65);
    run_op("k1", 64'h1, {1'b0, 64'h5, 64'h1}, 0, 3, 1'b0, 65);
    run_op("kB", 64'hB, rand_pt(), 0, 3, 1'b0, 0);
    run_op("k3_eqbase", 64'h3, rand_pt(), 1, 2, 1'b0, 0);
    run_op("k3_dbl_inf", 64'h3, rand_pt(), 2, 2, 1'b0, 0);
    b = rand_pt();
    b[128] = 1'b1;
    run_op("base_inf", {$urandom, $urandom}, b, 0, 3, 1'b0, 2);
    run_op("busy_start", 64'h2D, rand_pt(), 0, 2, 1'b1, 0);
    run_op("k_ones", '1, rand_pt(), 0, 1, 1'b0, 0);
    for (int r = 0; r < 6; r++) begin
      kr = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_op($sformatf("rand%0d", r), kr, rand_pt(), 0, int'($urandom_range(1, 4)), 1'b0, 0);
    end

    // Reset while a DOUBLE is outstanding
    b = rand_pt();
    stub_mode = 0;
    stub_lat  = 6;
    cur_base  = b;
    @(negedge clk);
    start = 1'b1; k = 64'hFF; base_pt = b;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (alu_en !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("rst alu_en_seen", 192'(alu_en), 192'(1'b1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst busy", 192'(busy), 192'(1'b0));
    chk("rst done", 192'(done), 192'(1'b0));
    chk("rst alu_en", 192'(alu_en), 192'(1'b0));
    chk("rst result", 192'(result), 192'(PT_INF));
    chk("rst alu_P", 192'(alu_P), 192'(PT_INF));
    chk("rst alu_Q", 192'(alu_Q), 192'(PT_INF));
    chk("rst alu_op", 192'(alu_op), 192'(2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("rst idle%0d", c), 192'({busy, done, alu_en}), 192'(3'b000));
    end
    run_op("rst_k2", 64'h2, b, 0, 3, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
